ad9226_capture: RTL and testbench
=================================

AD9226_CAPTURE -- requirements
Module: ad9226_capture

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per adc_clk period; even, range 2..16.
REQ-002 Parameter FIFO_DEPTH, default 16: sample buffer entries; power of two.
REQ-003 Parameter TWOS_COMP, default 0: 1 = convert offset-binary ADC code to two's complement.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  1 = run the converter and capture.
REQ-007 adc_clk  out  1  sample clock to the AD9226.
REQ-008 adc_data  in  12  AD9226 parallel output.
REQ-009 adc_otr  in  1  AD9226 out-of-range flag.
REQ-010 sample_data  out  12  head sample, driven onto the system-side ad9226 sample conduit.
REQ-011 sample_valid  out  1  head sample present; drives the beginbursttransfer strobe.
REQ-012 sample_ack_n  in  1  active-low accept, from writeresponsevalid_n.
REQ-013 overflow  out  1  sticky: at least one sample dropped.
REQ-014 out_of_range  out  1  sticky: a captured sample had adc_otr=1.
REQ-015 clear_flags  in  1  1 for one cycle clears overflow and out_of_range.
REQ-016 fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-017 Divider counter runs 0..CLK_DIV-1 while enable=1 and wraps to 0.
REQ-018 adc_clk SHALL be registered: 1 for counter 0..CLK_DIV/2-1, 0 otherwise.
REQ-019 When enable=0, the counter is held at 0 and adc_clk is held at 0.
REQ-020 On the first cycle with enable=1, the counter starts at 0.
REQ-021 adc_data and adc_otr SHALL be registered every clk cycle. The capture strobe fires on the cycle the counter equals CLK_DIV-1.
REQ-022 Flush counter: after enable rises, the first ADC_PIPE_LAT (7) capture strobes are discarded. They are not pushed and do not set flags.
REQ-023 The flush counter resets to 0 whenever enable=0.
REQ-024 Format: if TWOS_COMP=1, the stored value is the registered adc_data with bit 11 inverted. Otherwise the value is stored unchanged.
REQ-025 A non-discarded strobe with adc_otr=1 sets out_of_range. The sample is still pushed.
REQ-026 FIFO is show-ahead. sample_valid = (fifo_level != 0). sample_data = head entry.
REQ-027 Pop occurs when sample_valid=1 and sample_ack_n=0.
REQ-028 If sample_ack_n=0 while sample_valid=0, nothing happens.
REQ-029 sample_data SHALL stay stable while sample_valid=1 and no pop occurs.
REQ-030 Push on a non-discarded strobe if not full, or if full and a pop occurs in the same cycle. In the full-with-pop case, fifo_level is unchanged and overflow is not set.
REQ-031 If full with no pop, the sample is dropped and overflow is set. Contents are unchanged.
REQ-032 Simultaneous push and pop on a non-empty FIFO: fifo_level is unchanged.
REQ-033 Latency: a sample pushed into an empty FIFO at cycle t gives sample_valid=1 at t+1.
REQ-034 Read/write pointers wrap modulo FIFO_DEPTH.
REQ-035 Deasserting enable SHALL NOT flush the FIFO; buffered samples continue to drain.
REQ-036 clear_flags has priority over a same-cycle set.

Reset
REQ-037 While reset=1, all of the following hold:
 - adc_clk=0, sample_valid=0, sample_data=0, fifo_level=0
 - overflow=0, out_of_range=0
 - divider and flush counters = 0
 - FIFO pointers = 0
REQ-038 Reset overrides every other input, including mid-transfer.
REQ-039 Samples buffered before reset are discarded and are never presented afterward.

Structure
REQ-040 Shared package ad9226_pkg holds SAMPLE_W=12, ADC_PIPE_LAT=7 and the sample type.
REQ-041 The FIFO SHALL be the sub-module ad9226_sample_fifo (show-ahead, level output, same clock and reset).
REQ-042 Divider, flush counter, formatting and flags live in ad9226_capture.

Verification
REQ-043 Basic capture and latency:
 - Setup: CLK_DIV=4; enable rises; ADC model returns strobe index n.
 - Required: first 7 strobes dropped; first sample_data=7; sample_valid rises 1 cycle after that strobe.
 - adc_clk period is 4 cycles with 50% duty.
REQ-044 Overflow:
 - Stimulus: sample_ack_n held 1 for 20 strobes.
 - Required: fifo_level saturates at 16; overflow=1; draining yields 16 consecutive values with no gaps.
REQ-045 Full with simultaneous pop:
 - Stimulus: FIFO at 16; sample_ack_n=0 on the strobe cycle.
 - Required: level stays 16; overflow=0; new sample is at the tail.
REQ-046 TWOS_COMP=1 formatting:
 - adc_data 0x800 -> sample_data 0x000.
 - adc_data 0x000 -> 0x800.
 - adc_data 0xFFF -> 0x7FF.
REQ-047 Out-of-range flag:
 - Stimulus: adc_otr=1 on one post-flush strobe.
 - Required: out_of_range=1; clear_flags pulse -> 0 the next cycle.
REQ-048 Reset with data buffered:
 - Stimulus: reset with 5 samples buffered and sample_valid=1.
 - Required: next cycle sample_valid=0, fifo_level=0, adc_clk=0.
 - After release: a new 7-strobe flush occurs before the first sample.

Source files
------------

// File: rtl/ad9226_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the AD9226 capture path: sample width, converter
// pipeline latency and the output-format helper.
package ad9226_pkg;

    localparam int SAMPLE_W     = 12;
    localparam int ADC_PIPE_LAT = 7;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Offset-binary to two's complement is a flip of the MSB.
    function automatic sample_t format_sample(input sample_t raw, input bit twos_comp);
        sample_t formatted;
        formatted = raw;
        if (twos_comp) begin
            formatted[SAMPLE_W-1] = ~raw[SAMPLE_W-1];
        end
        return formatted;
    endfunction

endpackage

// File: rtl/ad9226_sample_fifo.sv
`timescale 1ns/1ps
// Show-ahead sample FIFO: the head entry is always visible on head_data_o,
// level_o reports occupancy. A push into a full FIFO is accepted only with a pop.
module ad9226_sample_fifo
    import ad9226_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  sample_t                push_data_i,
    input  logic                   pop_i,
    output sample_t                head_data_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    sample_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (level_q == '0);
    assign full_o  = (level_q == FULL_LEVEL);
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + (AW + 1)'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; the empty-gated head keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_data_o = empty ? '0 : mem_q[rd_ptr_q];
    assign level_o     = level_q;

endmodule

// File: rtl/ad9226_capture.sv
`timescale 1ns/1ps
// AD9226 capture: divides clk into the converter sample clock, skips the
// converter pipeline flush after enable, formats samples and buffers them.
module ad9226_capture
    import ad9226_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int TWOS_COMP  = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    output logic                        adc_clk,
    input  logic [SAMPLE_W-1:0]         adc_data,
    input  logic                        adc_otr,
    output logic [SAMPLE_W-1:0]         sample_data,
    output logic                        sample_valid,
    input  logic                        sample_ack_n,
    output logic                        overflow,
    output logic                        out_of_range,
    input  logic                        clear_flags,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int                   DIV_W      = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_HALF   = DIV_W'(CLK_DIV / 2);
    localparam int                   FLUSH_W    = $clog2(ADC_PIPE_LAT + 1);
    localparam logic [FLUSH_W-1:0]   FLUSH_DONE = FLUSH_W'(ADC_PIPE_LAT);

    logic [DIV_W-1:0]   div_q, div_d;
    logic               adc_clk_q, adc_clk_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    sample_t            data_q;
    logic               otr_q;
    logic               overflow_q, overflow_d;
    logic               oor_q, oor_d;

    logic               strobe;
    logic               keep;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    sample_t            push_data;

    assign strobe    = enable && (div_q == DIV_LAST);
    assign keep      = strobe && (flush_q == FLUSH_DONE);
    assign pop       = sample_valid && !sample_ack_n;
    assign drop      = keep && fifo_full && !pop;
    assign push_data = format_sample(data_q, TWOS_COMP != 0);

    always_comb begin
        div_d      = '0;
        flush_d    = '0;
        overflow_d = overflow_q | drop;
        oor_d      = oor_q | (keep && otr_q);
        if (enable) begin
            div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            flush_d = flush_q;
            if (strobe && (flush_q != FLUSH_DONE)) begin
                flush_d = flush_q + FLUSH_W'(1);
            end
        end
        // adc_clk is registered from the next count so it lines up with the counter.
        adc_clk_d = enable && (div_d < DIV_HALF);
        if (clear_flags) begin
            overflow_d = 1'b0;
            oor_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            adc_clk_q  <= 1'b0;
            flush_q    <= '0;
            data_q     <= '0;
            otr_q      <= 1'b0;
            overflow_q <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            adc_clk_q  <= adc_clk_d;
            flush_q    <= flush_d;
            data_q     <= adc_data;
            otr_q      <= adc_otr;
            overflow_q <= overflow_d;
            oor_q      <= oor_d;
        end
    end

    ad9226_sample_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (keep),
        .push_data_i(push_data),
        .pop_i      (pop),
        .head_data_o(sample_data),
        .full_o     (fifo_full),
        .level_o    (fifo_level)
    );

    assign adc_clk      = adc_clk_q;
    assign sample_valid = (fifo_level != '0);
    assign overflow     = overflow_q;
    assign out_of_range = oor_q;

endmodule

// File: tb/tb_ad9226_capture.sv
`timescale 1ns/1ps
// Directed bench for ad9226_capture: an offset-binary and a two's-complement
// instance share all inputs; a small ADC model updates data on adc_clk rises.
module tb_ad9226_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [11:0] adc_data;
    logic        adc_otr;
    logic        sample_ack_n;
    logic        clear_flags;

    logic        adc_clk, sample_valid, overflow, out_of_range;
    logic [11:0] sample_data;
    logic [4:0]  fifo_level;

    logic        adc_clk_t, sample_valid_t, overflow_t, out_of_range_t;
    logic [11:0] sample_data_t;
    logic [4:0]  fifo_level_t;

    int          total = 0;
    int          bad   = 0;
    int          n     = 0;
    logic [11:0] data_tab [32];
    logic        otr_tab  [32];

    always #5 clk = ~clk;

    ad9226_capture #(.CLK_DIV(4), .FIFO_DEPTH(16), .TWOS_COMP(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .adc_clk(adc_clk),
        .adc_data(adc_data), .adc_otr(adc_otr), .sample_data(sample_data),
        .sample_valid(sample_valid), .sample_ack_n(sample_ack_n),
        .overflow(overflow), .out_of_range(out_of_range),
        .clear_flags(clear_flags), .fifo_level(fifo_level)
    );

    ad9226_capture #(.CLK_DIV(4), .FIFO_DEPTH(16), .TWOS_COMP(1)) dut_tc (
        .clk(clk), .reset(reset), .enable(enable), .adc_clk(adc_clk_t),
        .adc_data(adc_data), .adc_otr(adc_otr), .sample_data(sample_data_t),
        .sample_valid(sample_valid_t), .sample_ack_n(sample_ack_n),
        .overflow(overflow_t), .out_of_range(out_of_range_t),
        .clear_flags(clear_flags), .fifo_level(fifo_level_t)
    );

    // ADC model: each adc_clk rise presents the table entry for strobe index n.
    initial begin : adc_model
        logic prev;
        prev     = 1'b0;
        adc_data = '0;
        adc_otr  = 1'b0;
        forever begin
            @(negedge clk);
            if (adc_clk && !prev) begin
                adc_data = (n < 32) ? data_tab[n] : n[11:0];
                adc_otr  = (n < 32) ? otr_tab[n] : 1'b0;
                n = n + 1;
            end
            prev = adc_clk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic fill_tab(input int base);
        for (int i = 0; i < 32; i++) begin
            data_tab[i] = 12'(base + i);
            otr_tab[i]  = 1'b0;
        end
    endtask

    // Called on the negedge where the first enabled, unreset cycle begins.
    task automatic wait_first_sample(input string tag, input logic [11:0] exp_data);
        int k;
        k = 0;
        while (!sample_valid && k < 100) begin
            tick(1);
            k++;
        end
        check({tag, "_latency"}, k, 32);
        check({tag, "_first_data"}, sample_data, exp_data);
    endtask

    task automatic drain(input string tag, input int cnt, input logic [11:0] first);
        for (int i = 0; i < cnt; i++) begin
            check(tag, sample_data, 32'(first) + i);
            sample_ack_n = 1'b0;
            tick(1);
        end
        sample_ack_n = 1'b1;
    endtask

    initial begin : stimulus
        int k;
        logic [11:0] exp_raw [3];
        logic [11:0] exp_tc  [3];

        reset        = 1'b1;
        enable       = 1'b1;
        sample_ack_n = 1'b1;
        clear_flags  = 1'b0;
        fill_tab(0);
        tick(3);

        // Reset holds everything at zero even with enable asserted.
        check("rst_adc_clk", adc_clk, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_data", sample_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_oor", out_of_range, 0);
        check("rst_tc_adc_clk", adc_clk_t, 0);
        check("rst_tc_valid", sample_valid_t, 0);
        check("rst_tc_data", sample_data_t, 0);
        check("rst_tc_level", fifo_level_t, 0);
        check("rst_tc_overflow", overflow_t, 0);
        check("rst_tc_oor", out_of_range_t, 0);

        // Basic capture: 7 strobes flushed, strobe 7 pushed, valid one cycle later.
        n     = 0;
        reset = 1'b0;
        wait_first_sample("basic", 12'd7);
        check("basic_level", fifo_level, 1);

        k = 0;
        while (adc_clk !== 1'b0 && k < 10) begin tick(1); k++; end
        while (adc_clk !== 1'b1 && k < 20) begin tick(1); k++; end
        check("adc_clk_rise_found", k < 20, 1);
        for (int i = 0; i < 8; i++) begin
            check("adc_clk_phase", adc_clk, (i % 4) < 2);
            tick(1);
        end

        // Overflow: ack held off long past 16 buffered samples.
        tick(100);
        check("ovf_level", fifo_level, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_head_stable", sample_data, 7);
        enable = 1'b0;
        tick(2);
        check("ovf_level_after_disable", fifo_level, 16);
        drain("ovf_drain", 16, 12'd7);
        check("ovf_drained_valid", sample_valid, 0);
        check("ovf_drained_level", fifo_level, 0);

        // Ack while empty does nothing.
        sample_ack_n = 1'b0;
        tick(3);
        sample_ack_n = 1'b1;
        check("empty_ack_level", fifo_level, 0);
        check("empty_ack_valid", sample_valid, 0);

        check("ovf_sticky", overflow, 1);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full with a pop on the strobe cycle: level stays 16, no overflow.
        fill_tab(0);
        n      = 0;
        enable = 1'b1;
        tick(95);
        check("fullpop_pre_level", fifo_level, 16);
        check("fullpop_pre_head", sample_data, 7);
        check("fullpop_pre_ovf", overflow, 0);
        sample_ack_n = 1'b0;
        tick(1);
        sample_ack_n = 1'b1;
        enable       = 1'b0;
        check("fullpop_level", fifo_level, 16);
        check("fullpop_ovf", overflow, 0);
        drain("fullpop_drain", 16, 12'd8);
        check("fullpop_drained_valid", sample_valid, 0);

        // Out-of-range: discarded strobe 3 ignored, strobe 9 sets, clear wins over strobe 10.
        fill_tab(0);
        otr_tab[3]  = 1'b1;
        otr_tab[9]  = 1'b1;
        otr_tab[10] = 1'b1;
        n      = 0;
        enable = 1'b1;
        tick(36);
        check("oor_flush_ignored", out_of_range, 0);
        tick(4);
        check("oor_set", out_of_range, 1);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check("oor_cleared", out_of_range, 0);
        tick(2);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check("oor_clear_priority", out_of_range, 0);
        tick(1);
        check("oor_stays_clear", out_of_range, 0);

        // Reset with 5 samples buffered discards them; a fresh flush follows.
        tick(3);
        check("rstbuf_level", fifo_level, 5);
        check("rstbuf_valid", sample_valid, 1);
        reset = 1'b1;
        tick(1);
        check("rstbuf_valid_after", sample_valid, 0);
        check("rstbuf_level_after", fifo_level, 0);
        check("rstbuf_adc_clk", adc_clk, 0);
        check("rstbuf_data", sample_data, 0);
        fill_tab(12'h100);
        n     = 0;
        reset = 1'b0;
        wait_first_sample("rstbuf", 12'h107);

        // Format: both instances see the same codes.
        reset = 1'b1;
        tick(2);
        fill_tab(0);
        data_tab[7] = 12'h800;
        data_tab[8] = 12'h000;
        data_tab[9] = 12'hFFF;
        exp_raw = '{12'h800, 12'h000, 12'hFFF};
        exp_tc  = '{12'h000, 12'h800, 12'h7FF};
        n     = 0;
        reset = 1'b0;
        tick(40);
        enable = 1'b0;
        check("fmt_level", fifo_level, 3);
        check("fmt_tc_level", fifo_level_t, 3);
        for (int i = 0; i < 3; i++) begin
            check("fmt_offset_binary", sample_data, exp_raw[i]);
            check("fmt_twos_comp", sample_data_t, exp_tc[i]);
            sample_ack_n = 1'b0;
            tick(1);
        end
        sample_ack_n = 1'b1;
        check("fmt_tc_drained", sample_valid_t, 0);
        check("fmt_tc_flags", {overflow_t, out_of_range_t, adc_clk_t}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
